id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register with a load-use interlock. It sits between decode and execute.
- It captures decoded fields each cycle and presents them to the execute stage and the forwarding unit (op, Rd, PCtoALU, Const, RegWrt).
- When the instruction in execute is a load whose destination is a source of the instruction in decode, it stalls fetch/decode and inserts bubbles.
- Branch flush from downstream overrides everything.

Parameters:
- DW, 32, datapath width of PC, operand and immediate fields.
- AW, 6, register address width.
- LOAD_LAT, 1, number of bubbles inserted per load-use hazard (legal range 1..7).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  branch/redirect taken; kill the instruction entering ID/EX.
- id_valid  in  1  decode slot holds a real instruction.
- id_op  in  4  opcode.
- id_rd, id_rs, id_rt  in  AW each  destination and source register addresses.
- id_pc  in  DW  instruction PC.
- id_rs_val, id_rt_val  in  DW each  register file read data.
- id_imm  in  DW  sign-extended immediate.
- id_regwrt, id_memrd, id_memwrt, id_pctoalu, id_const  in  1 each  decoded control bits.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  registered copy of id_valid.
- ex_op  out  4  registered copy of id_op.
- ex_rd, ex_rs, ex_rt  out  AW each  registered copies of id_rd, id_rs, id_rt.
- ex_pc, ex_rs_val, ex_rt_val, ex_imm  out  DW each  registered copies of the data fields.
- ex_regwrt, ex_memrd, ex_memwrt, ex_pctoalu, ex_const  out  1 each  registered copies of the control bits.
- bubble_cnt  out  16  saturating count of load-use bubbles inserted.

Behaviour:
- Reset (async, rst_n=0):
  - all ex_* outputs are 0, so a bubble with ex_rd=0.
  - bubble_cnt=0, state=RUN, internal down-counter cnt=0, stall=0.
- Hazard term (combinational): hz = id_valid & ex_valid & ex_memrd & (ex_rd!=0) & (ex_rd==id_rs | ex_rd==id_rt).
- States:
  - RUN: stall = hz & ~flush.
  - HOLD: stall = ~flush.
- Bubble load:
  - ex_valid, ex_regwrt, ex_memrd, ex_memwrt, ex_pctoalu, ex_const and ex_rd go to 0.
  - ex_op, ex_rs, ex_rt and the DW data fields hold their previous values.
- Per rising edge, in priority order:
  - flush=1: load a bubble; state<=RUN; cnt<=0; bubble_cnt unchanged. Flush in HOLD aborts the interlock.
  - RUN & hz: load a bubble; bubble_cnt+=1.
    - If LOAD_LAT==1, stay in RUN.
    - Otherwise state<=HOLD and cnt<=LOAD_LAT-1.
  - RUN & ~hz: capture all id_* fields unchanged (latency 1 cycle).
  - HOLD: load a bubble; bubble_cnt+=1; cnt<=cnt-1. If cnt==1, state<=RUN.
- The decode instruction is never lost. Upstream holds it while stall=1, and it is captured on the first RUN edge with hz=0.
- After the bubble(s), ex_memrd=0, so hz cannot re-trigger on the same load.
- id_valid=0 never causes a stall; an invalid decode slot is captured as-is with ex_valid=0.
- Control bits are captured as given even when id_valid=0. Decode is required to zero them for invalid slots.
- Rd/Rs/Rt equal to 0 never match in hz, because register 0 is never written.
- bubble_cnt saturates at 16'hFFFF with no wrap.
- Reset asserted mid-interlock: stall drops immediately, since it is combinational from reset state, and the pipeline reg reads as a bubble.

Test Plan:
- Reset, then id_valid=1, op=4'b0001, rd=3, rs=1, rt=2, id_regwrt=1: the next edge gives ex_rd=3, ex_valid=1 and ex_regwrt=1; stall=0 throughout.
- Load (memrd=1, rd=5) followed by an instruction with rs=5, LOAD_LAT=1:
  - stall=1 for exactly 1 cycle, with one bubble (ex_valid=0, ex_rd=0).
  - The dependent instruction then appears in ex_* with rs=5.
  - bubble_cnt=1.
- Same sequence with LOAD_LAT=3: stall is high for 3 consecutive cycles, 3 bubbles, then the dependent instruction is captured; bubble_cnt=3.
- Load with rd=0 followed by an instruction with rs=0: no stall; bubble_cnt=0.
- Flush during HOLD in the second stall cycle (LOAD_LAT=3):
  - stall drops in the same cycle and a bubble is loaded; state returns to RUN.
  - bubble_cnt=1, with the flush bubble not counted.
- Force 65536 load-use hazards: bubble_cnt reads 16'hFFFF and stays there. Then assert rst_n=0 mid-HOLD: all ex_* read 0, stall=0 and bubble_cnt=0 immediately.

Source files
------------

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decoded fields in from decode, registered fields out to
// execute and forwarding, plus the load-use stall back to fetch/decode.
interface id_ex_stage_reg_if #(
    parameter int DW = 32,
    parameter int AW = 6
);
    // Decode -> ID/EX
    logic          flush;
    logic          id_valid;
    logic [3:0]    id_op;
    logic [AW-1:0] id_rd;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic [DW-1:0] id_pc;
    logic [DW-1:0] id_rs_val;
    logic [DW-1:0] id_rt_val;
    logic [DW-1:0] id_imm;
    logic          id_regwrt;
    logic          id_memrd;
    logic          id_memwrt;
    logic          id_pctoalu;
    logic          id_const;

    // ID/EX -> execute / forwarding / upstream
    logic          stall;
    logic          ex_valid;
    logic [3:0]    ex_op;
    logic [AW-1:0] ex_rd;
    logic [AW-1:0] ex_rs;
    logic [AW-1:0] ex_rt;
    logic [DW-1:0] ex_pc;
    logic [DW-1:0] ex_rs_val;
    logic [DW-1:0] ex_rt_val;
    logic [DW-1:0] ex_imm;
    logic          ex_regwrt;
    logic          ex_memrd;
    logic          ex_memwrt;
    logic          ex_pctoalu;
    logic          ex_const;
    logic [15:0]   bubble_cnt;

    // Handshake: there is no valid/ready pair. While stall=1 the upstream
    // stages must hold the decode slot unchanged; it is consumed on the first
    // rising edge where stall=0. flush wins over stall and kills the slot.
    modport master (
        output flush, id_valid, id_op, id_rd, id_rs, id_rt,
               id_pc, id_rs_val, id_rt_val, id_imm,
               id_regwrt, id_memrd, id_memwrt, id_pctoalu, id_const,
        input  stall, ex_valid, ex_op, ex_rd, ex_rs, ex_rt,
               ex_pc, ex_rs_val, ex_rt_val, ex_imm,
               ex_regwrt, ex_memrd, ex_memwrt, ex_pctoalu, ex_const,
               bubble_cnt
    );

    modport slave (
        input  flush, id_valid, id_op, id_rd, id_rs, id_rt,
               id_pc, id_rs_val, id_rt_val, id_imm,
               id_regwrt, id_memrd, id_memwrt, id_pctoalu, id_const,
        output stall, ex_valid, ex_op, ex_rd, ex_rs, ex_rt,
               ex_pc, ex_rs_val, ex_rt_val, ex_imm,
               ex_regwrt, ex_memrd, ex_memwrt, ex_pctoalu, ex_const,
               bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use interlock: inserts LOAD_LAT bubbles when
// the load in execute feeds the instruction in decode; flush overrides everything.
module id_ex_stage_reg #(
    parameter int DW       = 32,
    parameter int AW       = 6,
    parameter int LOAD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    id_ex_stage_reg_if.slave   bus,
    output logic               o_dbg_state
);
    typedef enum logic {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam bit       C_MULTI     = (LOAD_LAT > 1);
    localparam logic [2:0] C_HOLD_INIT = 3'(LOAD_LAT - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [2:0]    r_cnt;
    logic [2:0]    w_next_cnt;

    logic          w_hz;
    logic          w_stall;
    logic          w_count;
    logic          w_bubble;

    logic          r_valid;
    logic [3:0]    r_op;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_rs;
    logic [AW-1:0] r_rt;
    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_rs_val;
    logic [DW-1:0] r_rt_val;
    logic [DW-1:0] r_imm;
    logic          r_regwrt;
    logic          r_memrd;
    logic          r_memwrt;
    logic          r_pctoalu;
    logic          r_const;
    logic [15:0]   r_bubble_cnt;

    // Register 0 is never written, so a load to r0 cannot create a dependency.
    assign w_hz = bus.id_valid & r_valid & r_memrd & (|r_rd) &
                  ((r_rd == bus.id_rs) | (r_rd == bus.id_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (bus.flush) begin
            w_next_state = S_RUN;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_hz && C_MULTI) begin
                        w_next_state = S_HOLD;
                        w_next_cnt   = C_HOLD_INIT;
                    end
                end
                S_HOLD: begin
                    w_next_cnt = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        w_next_state = S_RUN;
                    end
                end
                default: begin
                    w_next_state = S_RUN;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    // A counted bubble is exactly a stalled cycle; the flush bubble is not counted.
    always_comb begin
        w_stall = 1'b0;
        w_count = 1'b0;
        case (r_state)
            S_RUN:   w_stall = w_hz & ~bus.flush;
            S_HOLD:  w_stall = ~bus.flush;
            default: w_stall = 1'b0;
        endcase
        w_count  = w_stall;
        w_bubble = bus.flush | w_stall;
    end

    // A bubble clears only the fields that can cause side effects or hazards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_op      <= '0;
            r_rd      <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_pc      <= '0;
            r_rs_val  <= '0;
            r_rt_val  <= '0;
            r_imm     <= '0;
            r_regwrt  <= 1'b0;
            r_memrd   <= 1'b0;
            r_memwrt  <= 1'b0;
            r_pctoalu <= 1'b0;
            r_const   <= 1'b0;
        end else if (w_bubble) begin
            r_valid   <= 1'b0;
            r_rd      <= '0;
            r_regwrt  <= 1'b0;
            r_memrd   <= 1'b0;
            r_memwrt  <= 1'b0;
            r_pctoalu <= 1'b0;
            r_const   <= 1'b0;
        end else begin
            r_valid   <= bus.id_valid;
            r_op      <= bus.id_op;
            r_rd      <= bus.id_rd;
            r_rs      <= bus.id_rs;
            r_rt      <= bus.id_rt;
            r_pc      <= bus.id_pc;
            r_rs_val  <= bus.id_rs_val;
            r_rt_val  <= bus.id_rt_val;
            r_imm     <= bus.id_imm;
            r_regwrt  <= bus.id_regwrt;
            r_memrd   <= bus.id_memrd;
            r_memwrt  <= bus.id_memwrt;
            r_pctoalu <= bus.id_pctoalu;
            r_const   <= bus.id_const;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_count && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bus.stall      = w_stall;
    assign bus.ex_valid   = r_valid;
    assign bus.ex_op      = r_op;
    assign bus.ex_rd      = r_rd;
    assign bus.ex_rs      = r_rs;
    assign bus.ex_rt      = r_rt;
    assign bus.ex_pc      = r_pc;
    assign bus.ex_rs_val  = r_rs_val;
    assign bus.ex_rt_val  = r_rt_val;
    assign bus.ex_imm     = r_imm;
    assign bus.ex_regwrt  = r_regwrt;
    assign bus.ex_memrd   = r_memrd;
    assign bus.ex_memwrt  = r_memwrt;
    assign bus.ex_pctoalu = r_pctoalu;
    assign bus.ex_const   = r_const;
    assign bus.bubble_cnt = r_bubble_cnt;
    assign o_dbg_state    = r_state;
endmodule
